// File: rtl/calc_entry_sequencer_pkg.sv
// Shared constants for the calculator entry sequencer: opcodes, FSM states, mailbox offsets.
package calc_pkg;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;
    localparam logic [3:0] OP_EQ  = 4'hE;
    localparam logic [3:0] OP_CLR = 4'hF;

    localparam int unsigned OFS_A  = 0;
    localparam int unsigned OFS_OP = 4;
    localparam int unsigned OFS_B  = 8;
    localparam int unsigned OFS_GO = 12;

    typedef enum logic [2:0] {
        ENTER_A,
        WR_A,
        WR_OP,
        ENTER_B,
        WR_B,
        WR_GO,
        WAIT_RES,
        SHOW_RES
    } state_e;

    function automatic logic is_arith(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_DIV);
    endfunction

endpackage

// File: rtl/calc_entry_sequencer_if.sv
// Key-event, result and memory-write bundle for calc_entry_sequencer.
interface calc_entry_sequencer_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              digit_valid;
    logic [3:0]        digit;
    logic              op_valid;
    logic [3:0]        op_code;
    logic              result_valid;
    logic [WIDTH-1:0]  result_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  display_num;
    logic [3:0]        digit_count;
    logic              busy;
    logic              error;

    modport slave (
        input  digit_valid, digit, op_valid, op_code, result_valid, result_data,
        output mem_we, mem_addr, mem_wdata, display_num, digit_count, busy, error
    );

    modport master (
        output digit_valid, digit, op_valid, op_code, result_valid, result_data,
        input  mem_we, mem_addr, mem_wdata, display_num, digit_count, busy, error
    );
endinterface

// File: rtl/calc_entry_sequencer_decimal_accumulator.sv
// Decimal operand accumulator: acc*10+digit with digit-count saturation at MAX_DIGITS.
module decimal_accumulator #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_DIGITS = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [3:0]       load_cnt,
    input  logic             push,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       count
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       count_q, count_d;

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        if (clear) begin
            acc_d   = '0;
            count_d = '0;
        end else if (load) begin
            acc_d   = load_val;
            count_d = load_cnt;
        end else if (push && (count_q != 4'(MAX_DIGITS))) begin
            acc_d   = (acc_q << 3) + (acc_q << 1) + WIDTH'(digit);
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign acc   = acc_q;
    assign count = count_q;

endmodule

// File: rtl/calc_entry_sequencer.sv
// Calculator front end: key events -> mailbox writes (A, op, B, go) -> result display.
// Optional result-wait timeout enabled by defining CALC_TIMEOUT_EN.
module calc_entry_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned       WIDTH          = 32,
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       MAX_DIGITS     = 9,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
    input logic                   clk,
    input logic                   reset,
    calc_entry_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             error_q, error_d;

    logic             acc_clear, acc_load, acc_push;
    logic [WIDTH-1:0] load_val, acc;
    logic [3:0]       load_cnt, count;

    logic key_clr, key_eq, key_arith, key_digit;

    // Operator strobe takes precedence: a simultaneous digit is dropped.
    assign key_clr   = bus.op_valid && (bus.op_code == OP_CLR);
    assign key_eq    = bus.op_valid && (bus.op_code == OP_EQ);
    assign key_arith = bus.op_valid && is_arith(bus.op_code);
    assign key_digit = bus.digit_valid && !bus.op_valid && (bus.digit <= 4'd9);

`ifdef CALC_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT_RES && !key_clr) tmo_d = tmo_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        result_d  = result_q;
        error_d   = error_q;
        acc_clear = 1'b0;
        acc_load  = 1'b0;
        acc_push  = 1'b0;
        load_val  = '0;
        load_cnt  = '0;
        if (key_clr) begin
            state_d   = ENTER_A;
            opcode_d  = '0;
            result_d  = '0;
            error_d   = 1'b0;
            acc_clear = 1'b1;
        end else begin
            unique case (state_q)
                ENTER_A: begin
                    if (key_arith) begin
                        opcode_d = bus.op_code;
                        state_d  = WR_A;
                    end else if (key_digit) begin
                        acc_push = 1'b1;
                    end
                end
                WR_A:  state_d = WR_OP;
                WR_OP: begin
                    acc_clear = 1'b1;
                    state_d   = ENTER_B;
                end
                ENTER_B: begin
                    if (key_eq)         state_d  = WR_B;
                    else if (key_digit) acc_push = 1'b1;
                end
                WR_B:  state_d = WR_GO;
                WR_GO: state_d = WAIT_RES;
                WAIT_RES: begin
                    if (bus.result_valid) begin
                        result_d = bus.result_data;
                        state_d  = SHOW_RES;
                    end
`ifdef CALC_TIMEOUT_EN
                    else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        error_d  = 1'b1;
                        result_d = '0;
                        state_d  = SHOW_RES;
                    end
`endif
                end
                SHOW_RES: begin
                    // Chaining reloads the accumulator with the result so WR_A writes it as A.
                    if (key_arith) begin
                        opcode_d = bus.op_code;
                        acc_load = 1'b1;
                        load_val = result_q;
                        error_d  = 1'b0;
                        state_d  = WR_A;
                    end else if (key_digit) begin
                        acc_load = 1'b1;
                        load_val = WIDTH'(bus.digit);
                        load_cnt = 4'd1;
                        opcode_d = '0;
                        result_d = '0;
                        error_d  = 1'b0;
                        state_d  = ENTER_A;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ENTER_A;
            opcode_q <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    decimal_accumulator #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .load     (acc_load),
        .load_val (load_val),
        .load_cnt (load_cnt),
        .push     (acc_push),
        .digit    (bus.digit),
        .acc      (acc),
        .count    (count)
    );

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            WR_A: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = BASE_ADDR + ADDR_W'(OFS_A);
                bus.mem_wdata = acc;
            end
            WR_OP: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = BASE_ADDR + ADDR_W'(OFS_OP);
                bus.mem_wdata = WIDTH'(opcode_q);
            end
            WR_B: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = BASE_ADDR + ADDR_W'(OFS_B);
                bus.mem_wdata = acc;
            end
            WR_GO: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = BASE_ADDR + ADDR_W'(OFS_GO);
                bus.mem_wdata = WIDTH'(1);
            end
            default: ;
        endcase
    end

    assign bus.display_num = (state_q == SHOW_RES) ? result_q : acc;
    assign bus.digit_count = count;
    assign bus.busy        = (state_q == WR_A) || (state_q == WR_OP) || (state_q == WR_B) ||
                             (state_q == WR_GO) || (state_q == WAIT_RES);
    assign bus.error       = error_q;

endmodule
